// File: rtl/layer1_result_drain_if.sv
// Layer-1 result drain bus: engine write side plus
// the outgoing channel-word stream and status.
interface layer1_result_drain_if #(
   parameter int CH = 8,
   parameter int DW = 16
);
   logic            save_enable;
   logic [15:0]     output_row;
   logic [15:0]     output_col;
   logic [CH*DW-1:0] output_data;
   logic            layer1_calculation_done;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic [15:0]     out_row;
   logic [15:0]     out_col;
   logic [3:0]      out_ch;
   logic            out_last;
   logic            drain_done;
   logic [15:0]     wr_count;
   logic            wr_err;

   modport master (
      output save_enable, output_row, output_col,
      output output_data, layer1_calculation_done,
      output out_ready,
      input  out_valid, out_data, out_row, out_col,
      input  out_ch, out_last, drain_done,
      input  wr_count, wr_err
   );

   modport slave (
      input  save_enable, output_row, output_col,
      input  output_data, layer1_calculation_done,
      input  out_ready,
      output out_valid, out_data, out_row, out_col,
      output out_ch, out_last, drain_done,
      output wr_count, wr_err
   );
endinterface

// File: rtl/layer1_result_drain.sv
// Captures layer-1 result words into a ROWS x COLS store and
// streams them out as channel words once the engine is done.
module layer1_result_drain #(
   parameter int ROWS = 30,
   parameter int COLS = 30,
   parameter int CH   = 8,
   parameter int DW   = 16
) (
   input logic clk,
   input logic rst,
   layer1_result_drain_if.slave bus
);
   localparam int DEPTH = ROWS * COLS;
   localparam int WW    = CH * DW;
   localparam int AW    = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

   state_t        state_q, state_d;
   logic [15:0]   row_q, row_d;
   logic [15:0]   col_q, col_d;
   logic [3:0]    ch_q, ch_d;
   logic [15:0]   wr_count_q, wr_count_d;
   logic          wr_err_q, wr_err_d;
   logic          done_q, done_d;
   logic [WW-1:0] store_q [DEPTH];

   logic          start;
   logic          in_range;
   logic          wr_en;
   logic          valid;
   logic          last;
   logic          fire;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [WW-1:0] rd_word;

   // Write qualification, start edge and stream decode
   always_comb begin
      start    = bus.layer1_calculation_done & ~done_q;
      in_range = (bus.output_row < 16'(ROWS)) &&
                 (bus.output_col < 16'(COLS));
      wr_en    = bus.save_enable && (state_q == IDLE) && in_range;
      wr_addr  = AW'(32'(bus.output_row) * COLS +
                     32'(bus.output_col));
      rd_addr  = AW'(32'(row_q) * COLS + 32'(col_q));
      valid    = (state_q == DRAIN);
      last     = valid && (row_q == 16'(ROWS - 1)) &&
                 (col_q == 16'(COLS - 1)) &&
                 (ch_q == 4'(CH - 1));
      fire     = valid && bus.out_ready;
      rd_word  = store_q[rd_addr];
   end

   // Next state, scan counters and write bookkeeping
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      ch_d       = ch_q;
      wr_count_d = wr_count_q;
      wr_err_d   = wr_err_q;
      done_d     = bus.layer1_calculation_done;
      if (wr_en)
         wr_count_d = wr_count_q + 16'd1;
      if (bus.save_enable && ((state_q == DRAIN) || !in_range))
         wr_err_d = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = DRAIN;
               row_d      = '0;
               col_d      = '0;
               ch_d       = '0;
               wr_count_d = '0;
            end
         end
         DRAIN: begin
            if (fire) begin
               if (ch_q == 4'(CH - 1)) begin
                  ch_d = '0;
                  if (col_q == 16'(COLS - 1)) begin
                     col_d = '0;
                     if (row_q == 16'(ROWS - 1))
                        row_d = '0;
                     else
                        row_d = row_q + 16'd1;
                  end else begin
                     col_d = col_q + 16'd1;
                  end
               end else begin
                  ch_d = ch_q + 4'd1;
               end
               if (last)
                  state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         row_q      <= '0;
         col_q      <= '0;
         ch_q       <= '0;
         wr_count_q <= '0;
         wr_err_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         ch_q       <= ch_d;
         wr_count_q <= wr_count_d;
         wr_err_q   <= wr_err_d;
         done_q     <= done_d;
      end
   end

   // Result store, cleared on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            store_q[i] <= '0;
      end else if (wr_en) begin
         store_q[wr_addr] <= bus.output_data;
      end
   end

   assign bus.out_valid  = valid;
   assign bus.out_data   = valid ? rd_word[32'(ch_q) * DW +: DW] : '0;
   assign bus.out_row    = row_q;
   assign bus.out_col    = col_q;
   assign bus.out_ch     = ch_q;
   assign bus.out_last   = last;
   assign bus.drain_done = (state_q == DONE);
   assign bus.wr_count   = wr_count_q;
   assign bus.wr_err     = wr_err_q;
endmodule

// File: tb/tb_layer1_result_drain.sv
// Directed-plus-random bench for layer1_result_drain with a
// flat-array reference of the result store and stream order.
module tb_layer1_result_drain;
   localparam int ROWS  = 30;
   localparam int COLS  = 30;
   localparam int CH    = 8;
   localparam int TOTAL = ROWS * COLS * CH;
   localparam int BOUND = TOTAL * 4 + 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   logic [127:0] ref_store [ROWS*COLS];
   int           ref_count = 0;
   logic         ref_err   = 1'b0;

   layer1_result_drain_if bus ();

   layer1_result_drain dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [191:0] obs,
                        input logic [191:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < ROWS * COLS; i++)
         ref_store[i] = '0;
      ref_count = 0;
      ref_err   = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check(tag, {bus.out_valid, bus.out_data, bus.out_row,
                  bus.out_col, bus.out_ch, bus.out_last,
                  bus.drain_done, bus.wr_count, bus.wr_err}, '0);
   endtask

   task automatic wr(input int r, input int c,
                     input logic [127:0] d);
      bus.save_enable = 1'b1;
      bus.output_row  = 16'(r);
      bus.output_col  = 16'(c);
      bus.output_data = d;
      step();
      bus.save_enable = 1'b0;
      if (r < ROWS && c < COLS) begin
         ref_store[r*COLS+c] = d;
         ref_count++;
      end else begin
         ref_err = 1'b1;
      end
   endtask

   task automatic drain(input bit bp, input int hold,
                        input bit extra, input bit wr_mid,
                        input int abort_at, input bit cyc_chk);
      int k;
      int cyc;
      int r;
      int c;
      int h;
      logic [127:0] w;
      logic [53:0]  exp;
      bus.layer1_calculation_done = 1'b1;
      step();
      bus.save_enable = 1'b0;
      ref_count = 0;
      k = 0;
      cyc = 0;
      while (k < TOTAL && cyc < BOUND) begin
         if (k == abort_at) begin
            rst = 1'b1;
            #1;
            check("abort_async", {bus.out_valid, bus.drain_done}, 0);
            bus.layer1_calculation_done = 1'b0;
            bus.out_ready = 1'b0;
            step();
            rst = 1'b0;
            clear_model();
            step();
            check_reset_vals("post_abort");
            return;
         end
         if (cyc == hold)
            bus.layer1_calculation_done = 1'b0;
         if (extra && cyc == 40)
            bus.layer1_calculation_done = 1'b1;
         if (extra && cyc == 45)
            bus.layer1_calculation_done = 1'b0;
         if (wr_mid && cyc == 30) begin
            bus.save_enable = 1'b1;
            bus.output_row  = 16'($urandom_range(0, ROWS - 1));
            bus.output_col  = 16'($urandom_range(0, COLS - 1));
            bus.output_data = {$urandom, $urandom, $urandom, $urandom};
            ref_err = 1'b1;
         end
         if (wr_mid && cyc == 31)
            bus.save_enable = 1'b0;
         bus.out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
         r = k / (COLS * CH);
         c = (k / CH) % COLS;
         h = k % CH;
         w = ref_store[r*COLS+c];
         exp = {1'b1, w[h*16 +: 16], 16'(r), 16'(c), 4'(h),
                k == TOTAL - 1};
         check("word", {bus.out_valid, bus.out_data, bus.out_row,
                        bus.out_col, bus.out_ch, bus.out_last}, exp);
         step();
         cyc++;
         if (bus.out_ready)
            k++;
      end
      bus.layer1_calculation_done = 1'b0;
      bus.out_ready = 1'b0;
      check("accepted", k, TOTAL);
      if (cyc_chk)
         check("cycles", cyc, TOTAL);
      check("drain_done", {bus.drain_done, bus.out_valid}, 2'b10);
      step();
      check("idle", {bus.drain_done, bus.out_valid,
                     bus.wr_count, bus.wr_err},
            {2'b00, 16'(ref_count), ref_err});
   endtask

   initial begin
      int r;
      int c;
      logic [127:0] d;
      bus.save_enable = 1'b0;
      bus.output_row  = '0;
      bus.output_col  = '0;
      bus.output_data = '0;
      bus.layer1_calculation_done = 1'b0;
      bus.out_ready   = 1'b0;
      clear_model();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      check_reset_vals("reset");

      wr(0, 0, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
      check("count_single", {bus.wr_count, bus.wr_err}, {16'd1, 1'b0});
      drain(0, 1, 0, 0, -1, 1);

      wr(30, 5, {$urandom, $urandom, $urandom, $urandom});
      wr(2, 31, {$urandom, $urandom, $urandom, $urandom});
      check("illegal", {bus.wr_count, bus.wr_err}, {16'd0, 1'b1});

      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++)
            wr(i, j, {8{16'(i * COLS + j)}});
      check("count_full", {bus.wr_count, bus.wr_err}, {16'd900, 1'b1});
      drain(0, 10, 1, 1, -1, 1);

      for (int i = 0; i < 20; i++) begin
         r = $urandom_range(0, ROWS - 1);
         c = $urandom_range(0, COLS - 1);
         wr(r, c, {$urandom, $urandom, $urandom, $urandom});
      end
      wr(7, 9, {$urandom, $urandom, $urandom, $urandom});
      wr(7, 9, {$urandom, $urandom, $urandom, $urandom});
      check("count_rand", bus.wr_count, 16'(ref_count));
      drain(1, 3, 0, 0, -1, 0);
      drain(1, 1, 0, 0, -1, 0);

      d = {$urandom, $urandom, $urandom, $urandom};
      bus.save_enable = 1'b1;
      bus.output_row  = 16'(ROWS - 1);
      bus.output_col  = 16'(COLS - 1);
      bus.output_data = d;
      ref_store[ROWS*COLS-1] = d;
      drain(0, 1, 0, 0, -1, 1);

      drain(1, 1, 0, 0, 100, 0);
      drain(0, 1, 0, 0, -1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule
